// File: rtl/fb_swap_pkg.sv
// Shared types and helpers for the framebuffer rotation controller.
// Buffer indices are two bits wide, enough for up to four buffers.
package fb_swap_pkg;

    localparam int IDX_W       = $clog2(4);
    localparam int MAX_BUFFERS = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } hs_state_e;

    function automatic logic [63:0] idx_to_addr(
        input logic [63:0]      base,
        input logic [63:0]      stride,
        input logic [IDX_W-1:0] idx
    );
        return base + stride * 64'(idx);
    endfunction

endpackage

// File: rtl/fb_free_pick.sv
// Lowest-set-bit priority encoder over the free-buffer mask.
// found is low when no buffer is free.
module fb_free_pick
    import fb_swap_pkg::*;
#(
    parameter int NUM_BUFFERS = 2
) (
    input  logic [NUM_BUFFERS-1:0] mask_i,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Scan downward so the lowest set bit is written last.
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Framebuffer rotation controller: renderer swap handshake, buffer
// ownership tracking and frame-aligned display buffer commit.
module fb_swap_ctrl
    import fb_swap_pkg::*;
#(
    parameter int                    NUM_BUFFERS    = 2,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] FB_BASE_ADDR   = 32'h01C00000,
    parameter logic [ADDR_WIDTH-1:0] FB_STRIDE      = 32'h00200000,
    parameter bit                    VSYNC_LOCK     = 1'b1,
    parameter int                    DROP_CNT_WIDTH = 16
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic                      swap_req,
    output logic                      swap_ack,
    input  logic                      frame_start,
    output logic [ADDR_WIDTH-1:0]     display_addr,
    output logic [ADDR_WIDTH-1:0]     render_addr,
    output logic                      swap_pending,
    output logic [DROP_CNT_WIDTH-1:0] dropped_frames
);

    localparam int N = NUM_BUFFERS;
    localparam logic [N-1:0] FREE_RST = ~N'(3);

    hs_state_e state_q, state_d;

    logic [IDX_W-1:0]          disp_q, disp_d;
    logic [IDX_W-1:0]          rend_q, rend_d;
    logic [IDX_W-1:0]          ready_q, ready_d;
    logic                      rv_q, rv_d;
    logic [N-1:0]              free_q, free_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic                      acc_q;

    logic             accept;
    logic             commit;
    logic             recycle;
    logic [N-1:0]     disp_oh;
    logic [N-1:0]     free_post;
    logic [N-1:0]     pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    assign accept  = swap_req && swap_ack;
    assign commit  = rv_q && (VSYNC_LOCK ? frame_start : acc_q);
    // A commit on the same edge empties the ready slot, so nothing is dropped.
    assign recycle = rv_q && !commit;
    assign disp_oh = N'(1) << disp_q;
    assign pick_oh = N'(1) << pick_idx;

    assign free_post = (commit && N >= 3) ? (free_q | disp_oh) : free_q;

    fb_free_pick #(
        .NUM_BUFFERS (N)
    ) u_pick (
        .mask_i  (free_post),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (N >= 3 || commit) state_d = RELEASE;
            RELEASE: if (!swap_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        swap_ack = (state_q == IDLE);
    end

    always_comb begin
        disp_d  = disp_q;
        rend_d  = rend_q;
        ready_d = ready_q;
        rv_d    = rv_q;
        free_d  = free_q;
        drop_d  = drop_q;
        if (commit) begin
            disp_d = ready_q;
            rv_d   = 1'b0;
            if (N == 2) rend_d = disp_q;
            else free_d = free_q | disp_oh;
        end
        if (accept) begin
            ready_d = rend_q;
            rv_d    = 1'b1;
            if (N >= 3) begin
                if (recycle) begin
                    rend_d = ready_q;
                    if (drop_q != '1)
                        drop_d = drop_q + DROP_CNT_WIDTH'(1);
                end else begin
                    rend_d = pick_idx;
                    free_d = free_post & ~pick_oh;
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            disp_q  <= '0;
            rend_q  <= IDX_W'(1);
            ready_q <= '0;
            rv_q    <= 1'b0;
            free_q  <= FREE_RST;
            drop_q  <= '0;
            acc_q   <= 1'b0;
        end else begin
            disp_q  <= disp_d;
            rend_q  <= rend_d;
            ready_q <= ready_d;
            rv_q    <= rv_d;
            free_q  <= free_d;
            drop_q  <= drop_d;
            acc_q   <= accept;
        end
    end

    assign display_addr = ADDR_WIDTH'(idx_to_addr(64'(FB_BASE_ADDR),
                                                  64'(FB_STRIDE), disp_q));
    assign render_addr  = ADDR_WIDTH'(idx_to_addr(64'(FB_BASE_ADDR),
                                                  64'(FB_STRIDE), rend_q));
    assign swap_pending   = rv_q;
    assign dropped_frames = drop_q;

    // With two buffers the render index aliases the ready one while pending.
    logic [N-1:0] rend_own, ready_own;
    logic         part_ok;

    always_comb begin
        rend_own  = (N == 2 && rv_q) ? '0 : (N'(1) << rend_q);
        ready_own = rv_q ? (N'(1) << ready_q) : '0;
        part_ok   = ((disp_oh | rend_own | ready_own | free_q) == '1)
                 && !(|(disp_oh & rend_own))
                 && !(|(disp_oh & ready_own))
                 && !(|(disp_oh & free_q))
                 && !(|(rend_own & ready_own))
                 && !(|(rend_own & free_q))
                 && !(|(ready_own & free_q));
    end

    always @(posedge aclk) begin
        if (!reset) begin
            assert (part_ok);
            assert (!(accept && N >= 3 && !recycle) || pick_found);
        end
    end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed scoreboard bench for fb_swap_ctrl in three configurations:
// double buffered, triple buffered, and double buffered without vsync lock.
module tb_fb_swap_ctrl;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic reset;

    logic        req2, fs2, ack2, pend2;
    logic [31:0] disp2, rend2;
    logic [15:0] drop2;

    logic        req3, fs3, ack3, pend3;
    logic [31:0] disp3, rend3;
    logic [15:0] drop3;

    logic        reqv, fsv, ackv, pendv;
    logic [31:0] dispv, rendv;
    logic [15:0] dropv;

    fb_swap_ctrl #(.NUM_BUFFERS(2), .VSYNC_LOCK(1'b1)) u_n2 (
        .aclk           (aclk),
        .reset          (reset),
        .swap_req       (req2),
        .swap_ack       (ack2),
        .frame_start    (fs2),
        .display_addr   (disp2),
        .render_addr    (rend2),
        .swap_pending   (pend2),
        .dropped_frames (drop2)
    );

    fb_swap_ctrl #(.NUM_BUFFERS(3), .VSYNC_LOCK(1'b1)) u_n3 (
        .aclk           (aclk),
        .reset          (reset),
        .swap_req       (req3),
        .swap_ack       (ack3),
        .frame_start    (fs3),
        .display_addr   (disp3),
        .render_addr    (rend3),
        .swap_pending   (pend3),
        .dropped_frames (drop3)
    );

    fb_swap_ctrl #(.NUM_BUFFERS(2), .VSYNC_LOCK(1'b0)) u_nv (
        .aclk           (aclk),
        .reset          (reset),
        .swap_req       (reqv),
        .swap_ack       (ackv),
        .frame_start    (fsv),
        .display_addr   (dispv),
        .render_addr    (rendv),
        .swap_pending   (pendv),
        .dropped_frames (dropv)
    );

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req2 = 0; fs2 = 0; req3 = 0; fs3 = 0; reqv = 0; fsv = 0;
        repeat (2) @(posedge aclk);
        #1;
        reset = 1'b0;

        push("rst_disp2", 32'h01C00000);
        push("rst_rend2", 32'h01E00000);
        push("rst_ack2", 32'd1);
        push("rst_pend2", 32'd0);
        push("rst_drop2", 32'd0);
        push("rst_rend3", 32'h01E00000);
        #1;
        pop_cmp(disp2);
        pop_cmp(rend2);
        pop_cmp(32'(ack2));
        pop_cmp(32'(pend2));
        pop_cmp(32'(drop2));
        pop_cmp(rend3);

        // Double buffered, request held until the frame boundary.
        req2 = 1'b1;
        push("n2_acc_ack", 32'd0);
        push("n2_acc_pend", 32'd1);
        push("n2_acc_disp", 32'h01C00000);
        tick();
        pop_cmp(32'(ack2));
        pop_cmp(32'(pend2));
        pop_cmp(disp2);
        for (int i = 0; i < 9; i++) begin
            push("n2_wait_ack", 32'd0);
            tick();
            pop_cmp(32'(ack2));
        end
        fs2 = 1'b1;
        push("n2_commit_disp", 32'h01E00000);
        push("n2_commit_rend", 32'h01C00000);
        push("n2_commit_pend", 32'd0);
        push("n2_commit_ack", 32'd0);
        tick();
        fs2 = 1'b0;
        pop_cmp(disp2);
        pop_cmp(rend2);
        pop_cmp(32'(pend2));
        pop_cmp(32'(ack2));
        req2 = 1'b0;
        push("n2_release_ack", 32'd1);
        tick();
        pop_cmp(32'(ack2));

        // Triple buffered: accept without frame boundary.
        req3 = 1'b1;
        push("n3_acc_rend", 32'h02000000);
        push("n3_acc_pend", 32'd1);
        push("n3_acc_ack", 32'd0);
        tick();
        pop_cmp(rend3);
        pop_cmp(32'(pend3));
        pop_cmp(32'(ack3));
        req3 = 1'b0;
        tick();
        push("n3_ack_back", 32'd1);
        tick();
        pop_cmp(32'(ack3));

        // Second accept overwrites the queued frame.
        req3 = 1'b1;
        push("n3_drop_cnt", 32'd1);
        push("n3_drop_rend", 32'h01E00000);
        tick();
        pop_cmp(32'(drop3));
        pop_cmp(rend3);
        req3 = 1'b0;
        tick();
        tick();
        fs3 = 1'b1;
        push("n3_fs_disp", 32'h02000000);
        push("n3_fs_pend", 32'd0);
        tick();
        fs3 = 1'b0;
        pop_cmp(disp3);
        pop_cmp(32'(pend3));

        // Queue a frame, then accept on the same edge as frame_start.
        req3 = 1'b1;
        push("n3_q_rend", 32'h01C00000);
        push("n3_q_pend", 32'd1);
        tick();
        pop_cmp(rend3);
        pop_cmp(32'(pend3));
        req3 = 1'b0;
        tick();
        tick();
        req3 = 1'b1;
        fs3  = 1'b1;
        push("n3_sim_disp", 32'h01E00000);
        push("n3_sim_rend", 32'h02000000);
        push("n3_sim_pend", 32'd1);
        push("n3_sim_drop", 32'd1);
        tick();
        req3 = 1'b0;
        fs3  = 1'b0;
        pop_cmp(disp3);
        pop_cmp(rend3);
        pop_cmp(32'(pend3));
        pop_cmp(32'(drop3));
        tick();
        tick();
        fs3 = 1'b1;
        push("n3_last_disp", 32'h01C00000);
        push("n3_last_pend", 32'd0);
        tick();
        fs3 = 1'b0;
        pop_cmp(disp3);
        pop_cmp(32'(pend3));

        // No vsync lock: commit on the edge after accept.
        reqv = 1'b1;
        push("nv_acc_disp", 32'h01C00000);
        push("nv_acc_ack", 32'd0);
        tick();
        pop_cmp(dispv);
        pop_cmp(32'(ackv));
        push("nv_commit_disp", 32'h01E00000);
        push("nv_commit_rend", 32'h01C00000);
        push("nv_commit_pend", 32'd0);
        tick();
        pop_cmp(dispv);
        pop_cmp(rendv);
        pop_cmp(32'(pendv));
        reqv = 1'b0;
        push("nv_release_ack", 32'd1);
        tick();
        pop_cmp(32'(ackv));
        reqv = 1'b1;
        push("nv_busy_disp", 32'h01E00000);
        push("nv_busy_pend", 32'd1);
        tick();
        pop_cmp(dispv);
        pop_cmp(32'(pendv));

        // Asynchronous reset while BUSY, sampled before any clock edge.
        #2;
        reset = 1'b1;
        push("ar_disp", 32'h01C00000);
        push("ar_rend", 32'h01E00000);
        push("ar_ack", 32'd1);
        push("ar_pend", 32'd0);
        push("ar_drop", 32'd0);
        push("ar_n3_rend", 32'h01E00000);
        push("ar_n3_drop", 32'd0);
        #1;
        pop_cmp(dispv);
        pop_cmp(rendv);
        pop_cmp(32'(ackv));
        pop_cmp(32'(pendv));
        pop_cmp(32'(dropv));
        pop_cmp(rend3);
        pop_cmp(32'(drop3));
        reqv = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
